// File: rtl/operand_loader_pkg.sv
// ---------------------------------------------------------------------------
// operand_loader_pkg
// Shared definitions for the operand loader:
//   state_e    - FSM state encoding (ST_LOAD=0, ST_PRESENT=1)
//   IDX_A..D   - operand slot indices driven on load_idx
//   TXN_CNT_W  - width of the optional handshake counter
// ---------------------------------------------------------------------------
package operand_loader_pkg;

  typedef enum logic {
    ST_LOAD    = 1'b0,
    ST_PRESENT = 1'b1
  } state_e;

  localparam logic [1:0] IDX_A = 2'd0;
  localparam logic [1:0] IDX_B = 2'd1;
  localparam logic [1:0] IDX_C = 2'd2;
  localparam logic [1:0] IDX_D = 2'd3;

  localparam int unsigned TXN_CNT_W = 8;

endpackage

// File: rtl/operand_loader.sv
// ---------------------------------------------------------------------------
// operand_loader
// Collects four serial W-bit beats into operand slots A..D, then presents the
// complete set to a downstream combinational stage until it is consumed.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   in_data    in   W   serial operand beat
//   in_valid   in   1   in_data valid
//   in_ready   out  1   beat accepted this cycle (high in LOAD)
//   clear      in   1   synchronous abort of a partial load / presented set
//   op_a..op_d out  W   assembled operand set
//   op_valid   out  1   operand set complete and stable (high in PRESENT)
//   op_ready   in   1   downstream consumes the operand set
//   load_idx   out  2   next slot to be written
//   txn_count  out  8   handshake counter (only with OPERAND_LOADER_TXN_CNT_EN)
//
// Configuration macro: OPERAND_LOADER_TXN_CNT_EN
// ---------------------------------------------------------------------------
module operand_loader
  import operand_loader_pkg::*;
#(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         clear,
  output logic [W-1:0] op_a,
  output logic [W-1:0] op_b,
  output logic [W-1:0] op_c,
  output logic [W-1:0] op_d,
  output logic         op_valid,
  input  logic         op_ready,
  output logic [1:0]   load_idx
`ifdef OPERAND_LOADER_TXN_CNT_EN
  ,
  output logic [TXN_CNT_W-1:0] txn_count
`endif
);

  state_e       state_q;
  logic [1:0]   load_idx_q;
  logic [W-1:0] ops_q [4];
  logic         op_valid_q;
  logic         in_ready_q;

  logic         accept_s;
  logic         handshake_s;

  // in_ready_q is high exactly in LOAD, so in_data is ignored elsewhere.
  assign accept_s    = in_valid & in_ready_q;
  assign handshake_s = op_valid_q & op_ready;

  // Load/present FSM with registered handshake outputs and operand storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_LOAD;
      load_idx_q <= IDX_A;
      op_valid_q <= 1'b0;
      in_ready_q <= 1'b1;
      for (int i = 0; i < 4; i++) begin
        ops_q[i] <= {W{1'b0}};
      end
    end else if (clear) begin
      // Abort wins over accept and handshake; operand contents are kept.
      state_q    <= ST_LOAD;
      load_idx_q <= IDX_A;
      op_valid_q <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (accept_s) begin
            ops_q[load_idx_q] <= in_data;
            if (load_idx_q == IDX_D) begin
              state_q    <= ST_PRESENT;
              load_idx_q <= IDX_A;
              op_valid_q <= 1'b1;
              in_ready_q <= 1'b0;
            end else begin
              load_idx_q <= load_idx_q + 2'd1;
            end
          end else begin
            load_idx_q <= load_idx_q;
          end
        end
        ST_PRESENT: begin
          if (handshake_s) begin
            state_q    <= ST_LOAD;
            op_valid_q <= 1'b0;
            in_ready_q <= 1'b1;
          end else begin
            op_valid_q <= 1'b1;
          end
        end
        default: begin
          state_q    <= ST_LOAD;
          load_idx_q <= IDX_A;
          op_valid_q <= 1'b0;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign op_a     = ops_q[IDX_A];
  assign op_b     = ops_q[IDX_B];
  assign op_c     = ops_q[IDX_C];
  assign op_d     = ops_q[IDX_D];
  assign op_valid = op_valid_q;
  assign in_ready = in_ready_q;
  assign load_idx = load_idx_q;

`ifdef OPERAND_LOADER_TXN_CNT_EN
  logic [TXN_CNT_W-1:0] txn_count_q;

  // Counts completed handshakes; clear suppresses the handshake, so it never counts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      txn_count_q <= {TXN_CNT_W{1'b0}};
    end else if (handshake_s && !clear) begin
      txn_count_q <= txn_count_q + {{(TXN_CNT_W-1){1'b0}}, 1'b1};
    end else begin
      txn_count_q <= txn_count_q;
    end
  end

  assign txn_count = txn_count_q;
`endif

endmodule

// File: doc/operand_loader.md
OPERAND_LOADER -- requirements
Module: operand_loader

Interface
REQ-001 W, 4, operand width in bits; all operand ports and in_data SHALL be W bits wide.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 in_data  input  W  serial operand nibble from the producer.
REQ-005 in_valid  input  1  in_data is valid this cycle.
REQ-006 in_ready  output  1  the block accepts in_data this cycle.
REQ-007 clear  input  1  synchronous abort of a partial load.
REQ-008 op_a, op_b, op_c, op_d  output  W each  assembled operand set for the downstream combinational operator stage.
REQ-009 op_valid  output  1  operand set complete and stable.
REQ-010 op_ready  input  1  downstream consumes the operand set.
REQ-011 load_idx  output  2  index of the next operand slot to be written (0=A, 1=B, 2=C, 3=D).

Function
REQ-012 The FSM SHALL have exactly two states, LOAD and PRESENT.
REQ-013 In LOAD, in_ready SHALL be 1 and op_valid SHALL be 0.
REQ-014 A beat is accepted when in_valid and in_ready are both 1 on a clock edge; the block SHALL write in_data into the slot at load_idx and increment load_idx.
REQ-015 Accepting the beat at load_idx=3 SHALL move the FSM to PRESENT and set load_idx to 0; op_valid SHALL go to 1 on the cycle after the 4th beat is accepted (latency 1).
REQ-016 In PRESENT, in_ready SHALL be 0 and op_a..op_d SHALL hold stable, with op_valid held at 1 until the handshake.
REQ-017 When op_valid and op_ready are both 1 on a clock edge, the FSM SHALL return to LOAD; op_valid SHALL be 0 on the next cycle.
REQ-018 Operand registers SHALL retain their values after a handshake; only new accepted beats overwrite them, slot by slot.
REQ-019 in_valid gaps in LOAD SHALL stall load_idx with no state change.
REQ-020 clear=1 SHALL force the FSM to LOAD with load_idx=0 on the next edge, and no beat SHALL be accepted that cycle.
REQ-021 clear SHALL take priority over a simultaneous accept or handshake, and SHALL leave the operand registers unchanged.
REQ-022 in_data is ignored whenever in_ready=0.
REQ-023 With in_valid and op_ready both held at 1, throughput SHALL be one operand set per 5 cycles.

Reset
REQ-024 rst=1 SHALL immediately force: state LOAD, load_idx 0, op_a..op_d 0, op_valid 0, in_ready 1 (after rst is released).
REQ-025 Reset asserted mid-load or in PRESENT SHALL discard the partial or complete set with no handshake.

Configuration
REQ-026 Macro OPERAND_LOADER_TXN_CNT_EN, when defined, SHALL add output txn_count (8 bits).
REQ-027 txn_count SHALL increment on each op_valid/op_ready handshake and wrap from 255 to 0.
REQ-028 txn_count SHALL reset to 0 on rst and SHALL be unaffected by clear.
REQ-029 Without the macro, the txn_count port and its counter logic SHALL be absent; all other behaviour is identical.

Structure
REQ-030 A shared package SHALL hold the state encoding (LOAD=0, PRESENT=1), the slot index constants IDX_A..IDX_D, and the counter width constant TXN_CNT_W=8.
REQ-031 The block SHALL be a single module with no sub-modules; the operand storage is a 4-entry register array indexed by load_idx.

Verification
REQ-032 Load 1100, 0110, 0010, 1100 with op_ready=0 -> op_a=1100, op_b=0110, op_c=0010, op_d=1100; op_valid=1 one cycle after the 4th beat; in_ready=0.
REQ-033 Hold op_ready=0 for 10 cycles in PRESENT while in_valid=1 with in_data=1111 -> outputs unchanged, in_ready=0; then op_ready=1 for 1 cycle -> op_valid=0 and in_ready=1 on the next cycle.
REQ-034 Load 2 beats (0001, 0010), pulse clear together with a 3rd beat (0011) -> load_idx=0, op_c unchanged; the next 4 beats (1010, 1011, 1100, 1101) -> op_a..op_d = 1010, 1011, 1100, 1101.
REQ-035 Assert rst asynchronously (mid-cycle) while in PRESENT -> op_valid=0 and op_a..op_d=0000 immediately, load_idx=0.
REQ-036 With in_valid=1 and op_ready=1 continuously -> op_valid pulses once every 5 cycles; with OPERAND_LOADER_TXN_CNT_EN defined, txn_count reads 0 after 256 handshakes.
